// File: rtl/frame_field_tracker_if.sv
// Bundle of the per-sample-point signals between the bit-level receiver and the frame field tracker.
// master drives the destuffed bit, the stuff mark and the error line; slave (the tracker) returns the decoded fields.
// Signals: RX/STUFF/ERR in; F_CRC_D/F_ACK_D/FIELD/ID/DLC/RTR/IDE/STUFF_EN/FRAME_DONE out of the tracker.
interface frame_field_tracker_if;
    logic        RX;
    logic        STUFF;
    logic        ERR;
    logic        F_CRC_D;
    logic        F_ACK_D;
    logic [4:0]  FIELD;
    logic [28:0] ID;
    logic [3:0]  DLC;
    logic        RTR;
    logic        IDE;
    logic        STUFF_EN;
    logic        FRAME_DONE;

    modport master (
        output RX, STUFF, ERR,
        input  F_CRC_D, F_ACK_D, FIELD, ID, DLC, RTR, IDE, STUFF_EN, FRAME_DONE
    );

    modport slave (
        input  RX, STUFF, ERR,
        output F_CRC_D, F_ACK_D, FIELD, ID, DLC, RTR, IDE, STUFF_EN, FRAME_DONE
    );
endinterface

// File: rtl/frame_field_tracker.sv
// Tracks which CAN frame field the next sampled bit belongs to and captures ID/DLC/RTR/IDE.
// Latency: one SP per bit; all outputs are state-decoded or registered, valid right after each rising SP.
// Backpressure: none; STUFF=1 freezes the tracker inside the stuffed region, ERR=0 aborts to the error wait.
// Ports: SP (clock), reset (sync, active-high), bus (slave side of frame_field_tracker_if).
module frame_field_tracker (
    input  logic                  SP,
    input  logic                  reset,
    frame_field_tracker_if.slave  bus
);

    typedef enum logic [4:0] {
        S_IDLE      = 5'd0,
        S_ID_A      = 5'd1,
        S_SRR_RTR   = 5'd2,
        S_IDE       = 5'd3,
        S_ID_B      = 5'd4,
        S_RTR_EXT   = 5'd5,
        S_R1        = 5'd6,
        S_R0        = 5'd7,
        S_DLC       = 5'd8,
        S_DATA      = 5'd9,
        S_CRC       = 5'd10,
        S_CRC_DELIM = 5'd11,
        S_ACK_SLOT  = 5'd12,
        S_ACK_DELIM = 5'd13,
        S_EOF       = 5'd14,
        S_IFS       = 5'd15,
        S_ERR_WAIT  = 5'd16
    } field_t;

    field_t      state, state_nxt;
    logic [6:0]  bit_cnt, cnt_nxt;
    logic [3:0]  ew_cnt, ew_nxt;
    logic        done_q, done_nxt;

    logic [28:0] id_q;
    logic [3:0]  dlc_q;
    logic        rtr_q;
    logic        ide_q;

    logic        in_stuffed;
    logic        abort;
    logic        hold;
    logic        last;
    logic [6:0]  field_len;
    logic [3:0]  dlc_shift;

    // DATA length in bits: remote frames carry none, DLC above 8 saturates at 8 bytes.
    function automatic logic [6:0] data_len(input logic [3:0] dlc, input logic rtr);
        if (rtr)
            return 7'd0;
        else if (dlc[3])
            return 7'd64;
        else
            return {1'b0, dlc[2:0], 3'b000};
    endfunction

    always_comb begin
        in_stuffed = (state >= S_ID_A) && (state <= S_CRC);
        abort      = !bus.ERR && (state != S_IDLE) && (state != S_ERR_WAIT);
        // ERR wins over STUFF, so a stuff sample only freezes when no abort is pending.
        hold       = !abort && bus.STUFF && in_stuffed;
        dlc_shift  = {dlc_q[2:0], bus.RX};

        case (state)
            S_ID_A:  field_len = 7'd11;
            S_ID_B:  field_len = 7'd18;
            S_DLC:   field_len = 7'd4;
            S_DATA:  field_len = data_len(dlc_q, rtr_q);
            S_CRC:   field_len = 7'd15;
            S_EOF:   field_len = 7'd7;
            S_IFS:   field_len = 7'd3;
            default: field_len = 7'd1;
        endcase
        last = (bit_cnt == field_len - 7'd1);
    end

    // State register
    always_ff @(posedge SP) begin
        if (reset) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            ew_cnt  <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
            ew_cnt  <= ew_nxt;
            done_q  <= done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        ew_nxt    = ew_cnt;
        done_nxt  = 1'b0;

        if (abort) begin
            state_nxt = S_ERR_WAIT;
            cnt_nxt   = '0;
            ew_nxt    = '0;
        end else if (!hold) begin
            cnt_nxt = last ? 7'd0 : bit_cnt + 7'd1;
            case (state)
                S_IDLE: begin
                    if (!bus.RX)
                        state_nxt = S_ID_A;
                end
                S_ID_A:      if (last) state_nxt = S_SRR_RTR;
                S_SRR_RTR:   state_nxt = S_IDE;
                S_IDE:       state_nxt = bus.RX ? S_ID_B : S_R0;
                S_ID_B:      if (last) state_nxt = S_RTR_EXT;
                S_RTR_EXT:   state_nxt = S_R1;
                S_R1:        state_nxt = S_R0;
                S_R0:        state_nxt = S_DLC;
                S_DLC: begin
                    // Decide on the just-completed DLC, not the register that updates this edge.
                    if (last)
                        state_nxt = (data_len(dlc_shift, rtr_q) == 7'd0) ? S_CRC : S_DATA;
                end
                S_DATA:      if (last) state_nxt = S_CRC;
                S_CRC:       if (last) state_nxt = S_CRC_DELIM;
                S_CRC_DELIM: state_nxt = S_ACK_SLOT;
                S_ACK_SLOT:  state_nxt = S_ACK_DELIM;
                S_ACK_DELIM: state_nxt = S_EOF;
                S_EOF: begin
                    if (last) begin
                        state_nxt = S_IFS;
                        done_nxt  = 1'b1;
                    end
                end
                S_IFS: begin
                    // A dominant bit during intermission is the SOF of the next frame.
                    if (!bus.RX) begin
                        state_nxt = S_ID_A;
                        cnt_nxt   = '0;
                    end else if (last) begin
                        state_nxt = S_IDLE;
                    end
                end
                S_ERR_WAIT: begin
                    if (!bus.RX) begin
                        ew_nxt = '0;
                    end else if (ew_cnt == 4'd10) begin
                        state_nxt = S_IDLE;
                        ew_nxt    = '0;
                    end else begin
                        ew_nxt = ew_cnt + 4'd1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Captured frame fields; frozen on stuff samples and left untouched on abort.
    always_ff @(posedge SP) begin
        if (reset) begin
            id_q  <= '0;
            dlc_q <= '0;
            rtr_q <= 1'b0;
            ide_q <= 1'b0;
        end else if (!abort && !hold) begin
            case (state)
                S_IDLE, S_IFS: begin
                    if (!bus.RX) begin
                        id_q  <= '0;
                        dlc_q <= '0;
                        rtr_q <= 1'b0;
                        ide_q <= 1'b0;
                    end
                end
                S_ID_A, S_ID_B: id_q  <= {id_q[27:0], bus.RX};
                // SRR_RTR always loads; an extended frame overwrites it in RTR_EXT.
                S_SRR_RTR:      rtr_q <= bus.RX;
                S_RTR_EXT:      rtr_q <= bus.RX;
                S_IDE:          ide_q <= bus.RX;
                S_DLC:          dlc_q <= dlc_shift;
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        bus.FIELD      = state;
        bus.F_CRC_D    = (state != S_CRC_DELIM);
        bus.F_ACK_D    = (state != S_ACK_DELIM);
        bus.STUFF_EN   = in_stuffed;
        bus.ID         = id_q;
        bus.DLC        = dlc_q;
        bus.RTR        = rtr_q;
        bus.IDE        = ide_q;
        bus.FRAME_DONE = done_q;
    end

endmodule

// File: tb/tb_frame_field_tracker.sv
// Directed bench for frame_field_tracker: sample queues per frame with hand-placed flag/done positions.
// Latency: checks sit 1 time unit after each rising SP.
// Backpressure: not applicable; stimulus is one sample per SP.
module tb_frame_field_tracker;

    logic SP = 1'b0;
    logic reset;
    frame_field_tracker_if bus();

    frame_field_tracker dut (
        .SP    (SP),
        .reset (reset),
        .bus   (bus)
    );

    always #5 SP = ~SP;

    int n_assert = 0;
    int n_fail   = 0;

    // {stuff, rx} per sample point
    logic [1:0] smp[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rx, input logic st, input logic er);
        bus.RX    = rx;
        bus.STUFF = st;
        bus.ERR   = er;
        @(posedge SP);
        #1;
    endtask

    task automatic push(input logic [63:0] v, input int n, input logic st = 1'b0);
        for (int i = n - 1; i >= 0; i--)
            smp.push_back({st, v[i]});
    endtask

    task automatic push_base_head(input logic [10:0] id, input logic rtr, input logic [3:0] dlc);
        push(64'd0, 1);
        push({53'd0, id}, 11);
        push({63'd0, rtr}, 1);
        push(64'd0, 1);
        push(64'd0, 1);
        push({60'd0, dlc}, 4);
    endtask

    task automatic push_tail();
        push(64'h1234, 15);
        push(64'd1, 1);
        push(64'd0, 1);
        push(64'd1, 1);
        push(64'h7F, 7);
        push(64'h7, 3);
    endtask

    task automatic check_reset_values();
        chk("rst_field",   {27'd0, bus.FIELD}, 32'd0);
        chk("rst_crc_d",   {31'd0, bus.F_CRC_D}, 32'd1);
        chk("rst_ack_d",   {31'd0, bus.F_ACK_D}, 32'd1);
        chk("rst_id",      {3'd0, bus.ID}, 32'd0);
        chk("rst_dlc",     {28'd0, bus.DLC}, 32'd0);
        chk("rst_rtr",     {31'd0, bus.RTR}, 32'd0);
        chk("rst_ide",     {31'd0, bus.IDE}, 32'd0);
        chk("rst_stuffen", {31'd0, bus.STUFF_EN}, 32'd0);
        chk("rst_done",    {31'd0, bus.FRAME_DONE}, 32'd0);
    endtask

    // Plays the queued samples; positions are 1-based sample numbers (0 = never).
    task automatic run_q(input int crc_pos, input int ack_pos, input int done_pos);
        int s;
        logic [1:0] cur;
        s = 0;
        while (smp.size() > 0) begin
            s++;
            cur = smp.pop_front();
            chk("crc_delim_flag", {31'd0, bus.F_CRC_D}, (s == crc_pos) ? 32'd0 : 32'd1);
            chk("ack_delim_flag", {31'd0, bus.F_ACK_D}, (s == ack_pos) ? 32'd0 : 32'd1);
            if (s == crc_pos) begin
                chk("field_crc_delim",  {27'd0, bus.FIELD}, 32'd11);
                chk("stuffen_at_delim", {31'd0, bus.STUFF_EN}, 32'd0);
            end
            if (s == crc_pos - 1) begin
                chk("field_crc_last",  {27'd0, bus.FIELD}, 32'd10);
                chk("stuffen_in_crc",  {31'd0, bus.STUFF_EN}, 32'd1);
            end
            step(cur[0], cur[1], 1'b1);
            chk("frame_done", {31'd0, bus.FRAME_DONE}, (s == done_pos) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        logic [28:0] ext_id;

        reset     = 1'b1;
        bus.RX    = 1'b1;
        bus.STUFF = 1'b0;
        bus.ERR   = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check_reset_values();
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b1);
        chk("idle_recessive", {27'd0, bus.FIELD}, 32'd0);

        // Base data frame, ID 0x123, DLC 2
        push_base_head(11'h123, 1'b0, 4'd2);
        push(64'hA5C3, 16);
        push_tail();
        run_q(51, 53, 60);
        chk("base_id",    {3'd0, bus.ID}, 32'h123);
        chk("base_dlc",   {28'd0, bus.DLC}, 32'd2);
        chk("base_rtr",   {31'd0, bus.RTR}, 32'd0);
        chk("base_ide",   {31'd0, bus.IDE}, 32'd0);
        chk("base_idle",  {27'd0, bus.FIELD}, 32'd0);

        // Extended remote frame, DLC 5
        push(64'd0, 1);
        push(64'h4A5, 11);
        push(64'd1, 1);
        push(64'd1, 1);
        push(64'h2B3C5, 18);
        push(64'd1, 1);
        push(64'd0, 1);
        push(64'd0, 1);
        push(64'd5, 4);
        push_tail();
        run_q(55, 57, 64);
        ext_id = {11'h4A5, 18'h2B3C5};
        chk("ext_id",  {3'd0, bus.ID}, {3'd0, ext_id});
        chk("ext_ide", {31'd0, bus.IDE}, 32'd1);
        chk("ext_rtr", {31'd0, bus.RTR}, 32'd1);
        chk("ext_dlc", {28'd0, bus.DLC}, 32'd5);

        // Base data frame, DLC 15 -> 64 data bits
        push_base_head(11'h055, 1'b0, 4'd15);
        push(64'hDEADBEEF01234567, 64);
        push_tail();
        run_q(99, 101, 108);
        chk("dlc15_dlc", {28'd0, bus.DLC}, 32'd15);
        chk("dlc15_id",  {3'd0, bus.ID}, 32'h055);

        // Base frame with stuff samples after SOF, in DATA, in CRC, and on CRC_DELIM
        push(64'd0, 1);
        smp.push_back(2'b11);
        push(64'h123, 11);
        push(64'd0, 1);
        push(64'd0, 1);
        push(64'd0, 1);
        push(64'd2, 4);
        push(64'hA, 4);
        smp.push_back(2'b11);
        push(64'h5C3, 12);
        push(64'h1, 3);
        smp.push_back(2'b10);
        push(64'h234, 12);
        push(64'd1, 1, 1'b1);
        push(64'd0, 1);
        push(64'd1, 1);
        push(64'h7F, 7);
        push(64'h7, 3);
        run_q(54, 56, 63);
        chk("stuff_id",  {3'd0, bus.ID}, 32'h123);
        chk("stuff_dlc", {28'd0, bus.DLC}, 32'd2);

        // Back-to-back SOF during IFS, then reset in CRC
        push_base_head(11'h123, 1'b0, 4'd2);
        push(64'hA5C3, 16);
        push(64'h1234, 15);
        push(64'd1, 1);
        push(64'd0, 1);
        push(64'd1, 1);
        push(64'h7F, 7);
        push(64'd1, 1);
        push(64'd0, 1);
        run_q(51, 53, 60);
        chk("ifs_sof_field", {27'd0, bus.FIELD}, 32'd1);
        chk("ifs_sof_id",    {3'd0, bus.ID}, 32'd0);
        chk("ifs_sof_dlc",   {28'd0, bus.DLC}, 32'd0);
        push(64'h7FF, 11);
        push(64'd0, 1);
        push(64'd0, 1);
        push(64'd0, 1);
        push(64'd1, 4);
        push(64'h3C, 8);
        push(64'h1F, 5);
        run_q(0, 0, 0);
        chk("pre_reset_field", {27'd0, bus.FIELD}, 32'd10);
        chk("pre_reset_id",    {3'd0, bus.ID}, 32'h7FF);
        reset = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        check_reset_values();
        push_base_head(11'h123, 1'b0, 4'd2);
        push(64'hA5C3, 16);
        push_tail();
        run_q(51, 53, 60);
        chk("post_reset_id",  {3'd0, bus.ID}, 32'h123);
        chk("post_reset_dlc", {28'd0, bus.DLC}, 32'd2);

        // Error abort in DATA (with STUFF=1 on the same sample), then recovery
        push_base_head(11'h123, 1'b0, 4'd2);
        push(64'hFF, 8);
        run_q(0, 0, 0);
        chk("err_pre_field", {27'd0, bus.FIELD}, 32'd9);
        step(1'b1, 1'b1, 1'b0);
        chk("err_field", {27'd0, bus.FIELD}, 32'd16);
        chk("err_done",  {31'd0, bus.FRAME_DONE}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, (i == 2) ? 1'b0 : 1'b1);
            chk("err_wait_5", {27'd0, bus.FIELD}, 32'd16);
        end
        step(1'b0, 1'b0, 1'b1);
        chk("err_wait_dom", {27'd0, bus.FIELD}, 32'd16);
        for (int i = 0; i < 11; i++) begin
            step(1'b1, (i == 4) ? 1'b1 : 1'b0, (i == 7) ? 1'b0 : 1'b1);
            chk("err_wait_11", {27'd0, bus.FIELD}, (i == 10) ? 32'd0 : 32'd16);
            chk("err_wait_done", {31'd0, bus.FRAME_DONE}, 32'd0);
        end
        step(1'b1, 1'b0, 1'b1);
        chk("err_idle_hold", {27'd0, bus.FIELD}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_field_tracker.md
FRAME_FIELD_TRACKER -- requirements
Module: frame_field_tracker

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
  SP  in  1  bit sample-point strobe; the block's only clock, rising edge.
  reset  in  1  synchronous, active-high reset, sampled on rising SP.
  RX  in  1  destuffed bus bit at this sample point; 0 = dominant.
  STUFF  in  1  1 = the bit sampled now is a stuff bit and is not frame content.
  ERR  in  1  active-low error from downstream checkers; 0 = abort the frame.
  F_CRC_D  out  1  active-low; 0 while the next bit to be sampled is the CRC delimiter.
  F_ACK_D  out  1  active-low; 0 while the next bit to be sampled is the ACK delimiter.
  FIELD  out  5  code of the field that holds the next bit to be sampled.
  ID  out  29  identifier shift register.
  DLC  out  4  received data length code.
  RTR  out  1  remote-frame flag.
  IDE  out  1  extended-frame flag.
  STUFF_EN  out  1  1 while the next bit lies in the stuffed region (ID_A through CRC).
  FRAME_DONE  out  1  one-SP pulse when the last EOF bit is consumed.
REQ-002 Reset SHALL be synchronous and active-high; the single clock SHALL be SP.

Function
REQ-003 The block SHALL be a Moore FSM. Each rising SP consumes the current RX bit and moves to the field of the next bit. All outputs SHALL be registered or decoded from state only.
REQ-004 FIELD codes SHALL be: 0 IDLE, 1 ID_A, 2 SRR_RTR, 3 IDE, 4 ID_B, 5 RTR_EXT, 6 R1, 7 R0, 8 DLC, 9 DATA, 10 CRC, 11 CRC_DELIM, 12 ACK_SLOT, 13 ACK_DELIM, 14 EOF, 15 IFS, 16 ERR_WAIT.
REQ-005 In IDLE:
  - RX=0 (SOF) SHALL clear ID, DLC, RTR and IDE, then go to ID_A.
  - RX=1 SHALL stay in IDLE.
REQ-006 Field lengths and transitions SHALL be:
  - ID_A: 11 bits -> SRR_RTR (1) -> IDE (1).
  - IDE=0: -> R0 (1) -> DLC (4).
  - IDE=1: -> ID_B (18) -> RTR_EXT (1) -> R1 (1) -> R0 (1) -> DLC (4).
  - Then DATA, CRC (15), CRC_DELIM (1), ACK_SLOT (1), ACK_DELIM (1), EOF (7), IFS (3), then IDLE.
REQ-007 Each ID_A and ID_B bit SHALL shift into ID at the LSB (ID <= {ID[27:0],RX}), so that:
  - a base identifier ends in ID[10:0];
  - an extended identifier ends in ID[28:0].
REQ-008 RTR and IDE SHALL be set as follows:
  - RTR SHALL latch RX from SRR_RTR when IDE=0, and from RTR_EXT when IDE=1.
  - IDE SHALL latch RX in field IDE.
REQ-009 DLC SHALL shift in MSB first.
REQ-010 The DATA length SHALL be 0 if RTR=1, otherwise 8*min(DLC,8) bits.
  - A length of 0 SHALL go from the DLC field directly to CRC.
REQ-011 Stuff handling:
  - STUFF=1 SHALL freeze state, bit counters and all data registers, in fields ID_A through CRC only.
  - STUFF SHALL be ignored in all other fields.
REQ-012 Flag timing:
  - F_CRC_D=0 exactly while FIELD=11, and F_ACK_D=0 exactly while FIELD=13; both SHALL be 1 otherwise.
  - A checker sampling RX on the same SP edge SHALL therefore see each flag low for exactly the delimiter bit.
REQ-013 FRAME_DONE SHALL be 1 for the single SP after the 7th EOF bit is consumed, and 0 otherwise.
REQ-014 Error abort:
  - ERR=0 in any state other than IDLE or ERR_WAIT SHALL go to ERR_WAIT and SHALL NOT pulse FRAME_DONE.
  - ERR SHALL have priority over STUFF.
REQ-015 ERR_WAIT SHALL count consecutive RX=1 bits.
  - RX=0 SHALL reset the count to 0.
  - The 11th consecutive recessive bit SHALL go to IDLE.
  - ERR is ignored while in ERR_WAIT.
REQ-016 An RX=0 bit in IFS SHALL be treated as SOF (REQ-005) and go to ID_A.

Reset
REQ-017 reset=1 at SP SHALL override all other inputs and produce these values on the next SP:
  - FIELD=0, F_CRC_D=1, F_ACK_D=1.
  - ID=0, DLC=0, RTR=0, IDE=0.
  - STUFF_EN=0, FRAME_DONE=0.
  - All counters 0.
REQ-018 The same values SHALL hold from power-up until the first SP edge.

Verification
REQ-019 Base data frame, ID 0x123, DLC=2:
  - ID[10:0]=0x123, DLC=2, RTR=0, IDE=0.
  - F_CRC_D=0 only during bit 51, F_ACK_D=0 only during bit 53.
  - FRAME_DONE pulses after bit 60.
REQ-020 Extended remote frame, DLC=5:
  - IDE=1, RTR=1, no DATA field.
  - F_CRC_D=0 only during bit 55, FRAME_DONE after bit 64.
REQ-021 Base data frame, DLC=15: DATA SHALL be 64 bits and F_CRC_D=0 during bit 99.
REQ-022 Same frame as REQ-019 with STUFF=1 samples:
  - Inserted after SOF, inside DATA and inside CRC: fields and flag timing shift by exactly the number of stuff samples.
  - STUFF=1 during CRC_DELIM: no effect.
REQ-023 ERR=0 during DATA:
  - Next FIELD=16.
  - 5 recessive bits, then 1 dominant, then 11 recessive: IDLE only after the final 11th recessive bit, and no FRAME_DONE.
REQ-024 reset=1 during CRC, with RX, STUFF and ERR arbitrary: all outputs at the REQ-017 values on the next SP; a new SOF restarts decoding correctly.
